// File: rtl/app_sel_pkg.sv
// ---------------------------------------------------------------------------
// Module   : app_sel_pkg
// Purpose  : shared types, defaults and width helper for the app selector
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package app_sel_pkg;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_SWAP = 1'b1
  } app_state_e;

  localparam int          SEG_W_DEF     = 12;
  localparam logic [11:0] SEG_BLANK_DEF = 12'hFFF;

  // Smallest width able to index n items, never less than one bit.
  function automatic int sel_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sel_debounce.sv
// ---------------------------------------------------------------------------
// Module   : sel_debounce
// Purpose  : two-flop synchroniser plus candidate/counter debounce of a bus
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module sel_debounce #(
  parameter int SEL_W        = 2,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] candidate,
  output logic             stable
);

  localparam int               CNT_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SEL_W-1:0] sync1_q, sync1_d;
  logic [SEL_W-1:0] sync2_q, sync2_d;
  logic [SEL_W-1:0] cand_q,  cand_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = sel_in;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    // Any movement of the synchronised value restarts qualification.
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign candidate = cand_q;
  assign stable    = (cnt_q == CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/app_select_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : app_select_ctrl
// Purpose  : debounced front-panel selector muxing N_APP SEG buses to board
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module app_select_ctrl
  import app_sel_pkg::*;
#(
  parameter int               N_APP        = 4,
  parameter int               SEL_W        = sel_clog2(N_APP),
  parameter int               SEG_W        = SEG_W_DEF,
  parameter int               DEBOUNCE_CYC = 1000000,
  parameter int               SWAP_RST_CYC = 16,
  parameter logic [SEG_W-1:0] SEG_BLANK    = SEG_W'(SEG_BLANK_DEF)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [SEL_W-1:0]       SEL_IN,
  input  logic [N_APP*SEG_W-1:0] SEG_IN,
  output logic [SEG_W-1:0]       SEG,
  output logic [N_APP-1:0]       APP_RESET,
  output logic [SEL_W-1:0]       ACTIVE,
  output logic                   SWITCHING,
  output logic                   CHANGED
);

  localparam int               SWC_W    = (SWAP_RST_CYC > 1) ? $clog2(SWAP_RST_CYC) : 1;
  localparam logic [SWC_W-1:0] SWC_LOAD = SWC_W'(SWAP_RST_CYC - 1);

  logic [SEL_W-1:0] cand;
  logic             stable;
  logic             cand_valid;
  logic [SEG_W-1:0] seg_sel;
  logic [N_APP-1:0] run_rst;

  app_state_e       state_q,     state_d;
  logic [SEL_W-1:0] active_q,    active_d;
  logic [SWC_W-1:0] swc_q,       swc_d;
  logic [SEG_W-1:0] seg_q,       seg_d;
  logic [N_APP-1:0] app_rst_q,   app_rst_d;
  logic             switching_q, switching_d;
  logic             changed_q,   changed_d;

  sel_debounce #(
    .SEL_W        (SEL_W),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sel_debounce (
    .clk       (CLK),
    .rst       (RESET),
    .sel_in    (SEL_IN),
    .candidate (cand),
    .stable    (stable)
  );

  // Selector codes beyond the populated apps are never acted on.
  assign cand_valid = (int'(cand) < N_APP);

  always_comb begin
    seg_sel = SEG_BLANK;
    run_rst = '1;
    for (int k = 0; k < N_APP; k++) begin
      if (active_q == SEL_W'(k)) begin
        seg_sel    = SEG_IN[k*SEG_W +: SEG_W];
        run_rst[k] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    swc_d       = swc_q;
    seg_d       = seg_q;
    app_rst_d   = app_rst_q;
    switching_d = switching_q;
    changed_d   = 1'b0;
    case (state_q)
      ST_RUN: begin
        seg_d       = seg_sel;
        app_rst_d   = run_rst;
        switching_d = 1'b0;
        if (stable && (cand != active_q) && cand_valid) begin
          active_d    = cand;
          state_d     = ST_SWAP;
          swc_d       = SWC_LOAD;
          app_rst_d   = '1;
          seg_d       = SEG_BLANK;
          changed_d   = 1'b1;
          switching_d = 1'b1;
        end
      end
      ST_SWAP: begin
        seg_d       = SEG_BLANK;
        app_rst_d   = '1;
        switching_d = 1'b1;
        if (swc_q == '0) begin
          state_d     = ST_RUN;
          seg_d       = seg_sel;
          app_rst_d   = run_rst;
          switching_d = 1'b0;
        end else begin
          swc_d = swc_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_SWAP;
        swc_d   = SWC_LOAD;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_SWAP;
      active_q    <= '0;
      swc_q       <= SWC_LOAD;
      seg_q       <= SEG_BLANK;
      app_rst_q   <= '1;
      switching_q <= 1'b1;
      changed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      swc_q       <= swc_d;
      seg_q       <= seg_d;
      app_rst_q   <= app_rst_d;
      switching_q <= switching_d;
      changed_q   <= changed_d;
    end
  end

  assign SEG       = seg_q;
  assign APP_RESET = app_rst_q;
  assign ACTIVE    = active_q;
  assign SWITCHING = switching_q;
  assign CHANGED   = changed_q;

endmodule

`default_nettype wire

// File: tb/tb_app_select_ctrl.sv
// ---------------------------------------------------------------------------
// Module   : tb_app_select_ctrl
// Purpose  : directed vector table plus corner sequences for app_select_ctrl
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_app_select_ctrl;

  localparam int N_APP = 3;
  localparam int SEL_W = 2;
  localparam int SEG_W = 12;
  localparam int DEB   = 4;
  localparam int SWAP  = 3;

  logic                   clk = 1'b0;
  logic                   RESET;
  logic [SEL_W-1:0]       SEL_IN;
  logic [N_APP*SEG_W-1:0] SEG_IN;
  logic [SEG_W-1:0]       SEG;
  logic [N_APP-1:0]       APP_RESET;
  logic [SEL_W-1:0]       ACTIVE;
  logic                   SWITCHING;
  logic                   CHANGED;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  app_select_ctrl #(
    .N_APP        (N_APP),
    .SEL_W        (SEL_W),
    .SEG_W        (SEG_W),
    .DEBOUNCE_CYC (DEB),
    .SWAP_RST_CYC (SWAP),
    .SEG_BLANK    (12'hFFF)
  ) dut (
    .CLK       (clk),
    .RESET     (RESET),
    .SEL_IN    (SEL_IN),
    .SEG_IN    (SEG_IN),
    .SEG       (SEG),
    .APP_RESET (APP_RESET),
    .ACTIVE    (ACTIVE),
    .SWITCHING (SWITCHING),
    .CHANGED   (CHANGED)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  sel;
    logic [11:0] seg;
    logic [2:0]  arst;
    logic [1:0]  act;
    logic        sw;
    logic        ch;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] app_seg(input logic [1:0] a);
    case (a)
      2'd0:    return 12'h0A0;
      2'd1:    return 12'h0B1;
      default: return 12'h0C2;
    endcase
  endfunction

  function automatic logic [2:0] run_mask(input logic [1:0] a);
    case (a)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  task automatic add(input int n, input logic rst, input logic [1:0] sel, input logic [11:0] seg,
                     input logic [2:0] arst, input logic [1:0] act, input logic sw, input logic ch);
    vec_t v;
    v = '{rst, sel, seg, arst, act, sw, ch};
    repeat (n) vecs.push_back(v);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Switch from a settled state; a clean edge must land exactly 7 cycles later.
  task automatic switch_to(input logic [1:0] v, input string tag);
    bit found;
    int lat;
    found  = 1'b0;
    lat    = 0;
    SEL_IN = v;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle();
      lat++;
      if (CHANGED) found = 1'b1;
    end
    chk({tag, "_changed"}, 32'(found), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd7);
    chk({tag, "_active"}, 32'(ACTIVE), 32'(v));
    repeat (SWAP) cycle();
    chk({tag, "_seg"}, 32'(SEG), 32'(app_seg(v)));
    chk({tag, "_appreset"}, 32'(APP_RESET), 32'(run_mask(v)));
  endtask

  // Reset vector must be all ones while switching, otherwise only the active app runs.
  always @(negedge clk) begin
    if (mon_en) begin
      if (SWITCHING) chk("inv_swap_allreset", 32'(APP_RESET), 32'h7);
      else           chk("inv_run_onehot", 32'(APP_RESET), 32'(run_mask(ACTIVE)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   bad;
    bit   found;
    bit   saw_run;
    int   lat;

    SEG_IN = {12'h0C2, 12'h0B1, 12'h0A0};
    RESET  = 1'b1;
    SEL_IN = 2'd0;
    mon_en = 1'b1;

    // Reset, clean switch to 2, out-of-range hold, then switch to 1.
    add(2,  1'b1, 2'd0, 12'hFFF, 3'b111, 2'd0, 1'b1, 1'b0);
    add(2,  1'b0, 2'd0, 12'hFFF, 3'b111, 2'd0, 1'b1, 1'b0);
    add(1,  1'b0, 2'd0, 12'h0A0, 3'b110, 2'd0, 1'b0, 1'b0);
    add(6,  1'b0, 2'd2, 12'h0A0, 3'b110, 2'd0, 1'b0, 1'b0);
    add(1,  1'b0, 2'd2, 12'hFFF, 3'b111, 2'd2, 1'b1, 1'b1);
    add(2,  1'b0, 2'd2, 12'hFFF, 3'b111, 2'd2, 1'b1, 1'b0);
    add(2,  1'b0, 2'd2, 12'h0C2, 3'b011, 2'd2, 1'b0, 1'b0);
    add(20, 1'b0, 2'd3, 12'h0C2, 3'b011, 2'd2, 1'b0, 1'b0);
    add(6,  1'b0, 2'd1, 12'h0C2, 3'b011, 2'd2, 1'b0, 1'b0);
    add(1,  1'b0, 2'd1, 12'hFFF, 3'b111, 2'd1, 1'b1, 1'b1);
    add(2,  1'b0, 2'd1, 12'hFFF, 3'b111, 2'd1, 1'b1, 1'b0);
    add(2,  1'b0, 2'd1, 12'h0B1, 3'b101, 2'd1, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      RESET  = vecs[i].rst;
      SEL_IN = vecs[i].sel;
      cycle();
      chk($sformatf("vec%0d_seg", i),       32'(SEG),       32'(vecs[i].seg));
      chk($sformatf("vec%0d_appreset", i),  32'(APP_RESET), 32'(vecs[i].arst));
      chk($sformatf("vec%0d_active", i),    32'(ACTIVE),    32'(vecs[i].act));
      chk($sformatf("vec%0d_switching", i), 32'(SWITCHING), 32'(vecs[i].sw));
      chk($sformatf("vec%0d_changed", i),   32'(CHANGED),   32'(vecs[i].ch));
    end

    // Bounce: 1/0 every 3 cycles never qualifies, final hold of 1 does.
    switch_to(2'd0, "pre_bounce");
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      SEL_IN = (k % 2 == 0) ? 2'd1 : 2'd0;
      repeat (3) begin
        cycle();
        if (CHANGED) bad = 1'b1;
      end
    end
    chk("bounce_no_changed", 32'(bad), 32'd0);
    SEL_IN = 2'd1;
    bad    = 1'b0;
    repeat (6) begin
      cycle();
      if (CHANGED) bad = 1'b1;
    end
    chk("bounce_early_changed", 32'(bad), 32'd0);
    cycle();
    chk("bounce_changed", 32'(CHANGED), 32'd1);
    chk("bounce_active", 32'(ACTIVE), 32'd1);
    repeat (SWAP) cycle();
    chk("bounce_seg", 32'(SEG), 32'h0B1);

    // Selector moves to 2 while the swap to 1 is still running.
    switch_to(2'd0, "pre_swapchg");
    SEL_IN = 2'd1;
    repeat (7) cycle();
    chk("swapchg_first_changed", 32'(CHANGED), 32'd1);
    chk("swapchg_first_active", 32'(ACTIVE), 32'd1);
    SEL_IN  = 2'd2;
    saw_run = 1'b0;
    found   = 1'b0;
    lat     = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      lat++;
      if (!SWITCHING && SEG == 12'h0B1 && ACTIVE == 2'd1) saw_run = 1'b1;
      if (CHANGED) found = 1'b1;
    end
    chk("swapchg_run_seen", 32'(saw_run), 32'd1);
    chk("swapchg_second_changed", 32'(found), 32'd1);
    chk("swapchg_latency", 32'(lat), 32'd7);
    chk("swapchg_second_active", 32'(ACTIVE), 32'd2);

    // Reset pulse in the middle of a swap toward app 2.
    switch_to(2'd0, "pre_midrst");
    SEL_IN = 2'd2;
    repeat (7) cycle();
    chk("midrst_changed", 32'(CHANGED), 32'd1);
    chk("midrst_target", 32'(ACTIVE), 32'd2);
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    chk("midrst_active", 32'(ACTIVE), 32'd0);
    chk("midrst_appreset", 32'(APP_RESET), 32'h7);
    chk("midrst_seg", 32'(SEG), 32'hFFF);
    chk("midrst_switching", 32'(SWITCHING), 32'd1);
    bad = 1'b0;
    repeat (SWAP) begin
      cycle();
      if (CHANGED) bad = 1'b1;
    end
    chk("midrst_no_changed", 32'(bad), 32'd0);
    chk("midrst_run_active", 32'(ACTIVE), 32'd0);
    chk("midrst_run_seg", 32'(SEG), 32'h0A0);
    chk("midrst_run_switching", 32'(SWITCHING), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (CHANGED) found = 1'b1;
    end
    chk("midrst_requal_changed", 32'(found), 32'd1);
    chk("midrst_requal_active", 32'(ACTIVE), 32'd2);
    repeat (SWAP) cycle();
    chk("midrst_requal_seg", 32'(SEG), 32'h0C2);
    chk("midrst_requal_appreset", 32'(APP_RESET), 32'h3);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
